// File: rtl/cacheram_arb_pkg.sv
// Shared definitions for the two-port cache RAM arbiter: lock state encodings
// and requester index constants.
package cacheram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKED_0 = 2'd1,
    LOCKED_1 = 2'd2
  } arb_state_e;

  localparam int REQ_P0 = 0;
  localparam int REQ_P1 = 1;

endpackage

// File: rtl/cacheram_arb_if.sv
// One requester port of the cache RAM arbiter.
// Handshake: the requester raises req with lock/we/addr/bsel/dataw and holds all
// of them stable until gnt; an access is accepted in any cycle with req && gnt.
// rvalid pulses one cycle after an accepted read, with datar valid in that cycle.
interface cacheram_arb_if #(
  parameter int AW       = 11,
  parameter int BYTE_NUM = 16
);
  localparam int DW = BYTE_NUM * 8;

  logic                req;
  logic                lock;
  logic                we;
  logic [AW-1:0]       addr;
  logic [BYTE_NUM-1:0] bsel;
  logic [DW-1:0]       dataw;
  logic                gnt;
  logic                rvalid;
  logic [DW-1:0]       datar;

  modport master (output req, lock, we, addr, bsel, dataw, input gnt, rvalid, datar);
  modport slave  (input req, lock, we, addr, bsel, dataw, output gnt, rvalid, datar);

endinterface

// File: rtl/cacheram_arb_rr_arb2.sv
// Two-way round-robin selector: on contention the requester that did not win
// last time (last = index of previous winner) is chosen; output is one-hot.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/cacheram_arb.sv
// Two-requester arbiter in front of a single-port synchronous cache RAM, with
// grant locking. Optional macro CACHERAM_ARB_RHOLD_EN holds read data between reads.
module cacheram_arb
  import cacheram_arb_pkg::*;
#(
  parameter int DEEPTH   = 2048,
  parameter int BYTE_NUM = 16,
  localparam int AW = $clog2(DEEPTH),
  localparam int DW = BYTE_NUM * 8
) (
  input  logic                clk,
  input  logic                rst,
  cacheram_arb_if.slave       p0,
  cacheram_arb_if.slave       p1,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [BYTE_NUM-1:0] ram_bsel,
  output logic [DW-1:0]       ram_dataw,
  input  logic [DW-1:0]       ram_datar,
  output arb_state_e          state
);

  arb_state_e state_d;
  logic       last;
  logic [1:0] rd_pend;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic [1:0] rvalid;
  logic       lock_keep0;
  logic       lock_keep1;

  rr_arb2 u_rr (
    .req  ({p1.req, p0.req}),
    .last (last),
    .gnt  (rr_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      rd_pend <= '0;
    end else begin
      state <= state_d;
      if (|gnt) last <= gnt[REQ_P1];
      rd_pend <= {gnt[REQ_P1] & ~p1.we, gnt[REQ_P0] & ~p0.we};
    end
  end

  // A lock only survives while its owner keeps both req and lock high;
  // otherwise the cycle is arbitrated exactly as in IDLE.
  always_comb begin
    lock_keep0 = (state == LOCKED_0) && p0.req && p0.lock;
    lock_keep1 = (state == LOCKED_1) && p1.req && p1.lock;
    gnt        = '0;
    if (!rst) begin
      if (lock_keep0)      gnt = 2'b01;
      else if (lock_keep1) gnt = 2'b10;
      else                 gnt = rr_gnt;
    end
    state_d = IDLE;
    if (gnt[REQ_P0] && p0.lock)      state_d = LOCKED_0;
    else if (gnt[REQ_P1] && p1.lock) state_d = LOCKED_1;
  end

  always_comb begin
    rvalid    = rd_pend & {2{~rst}};
    ram_ce    = |gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_bsel  = '0;
    ram_dataw = '0;
    if (gnt[REQ_P0]) begin
      ram_we    = p0.we;
      ram_addr  = p0.addr;
      ram_bsel  = p0.bsel;
      ram_dataw = p0.dataw;
    end else if (gnt[REQ_P1]) begin
      ram_we    = p1.we;
      ram_addr  = p1.addr;
      ram_bsel  = p1.bsel;
      ram_dataw = p1.dataw;
    end
  end

  assign p0.gnt    = gnt[REQ_P0];
  assign p1.gnt    = gnt[REQ_P1];
  assign p0.rvalid = rvalid[REQ_P0];
  assign p1.rvalid = rvalid[REQ_P1];

`ifdef CACHERAM_ARB_RHOLD_EN
  logic [DW-1:0] datar_q0;
  logic [DW-1:0] datar_q1;

  always_ff @(posedge clk) begin
    if (rst) begin
      datar_q0 <= '0;
      datar_q1 <= '0;
    end else begin
      if (rvalid[REQ_P0]) datar_q0 <= ram_datar;
      if (rvalid[REQ_P1]) datar_q1 <= ram_datar;
    end
  end

  assign p0.datar = rvalid[REQ_P0] ? ram_datar : datar_q0;
  assign p1.datar = rvalid[REQ_P1] ? ram_datar : datar_q1;
`else
  assign p0.datar = ram_datar;
  assign p1.datar = ram_datar;
`endif

endmodule
